// File: rtl/exec_stage_pipelined.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative shift-add multiplier,
// with valid/ready handshakes on both sides and a registered result.
module exec_stage_pipelined #(
  parameter int DBITS               = 32,
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int NUM_FWD             = 2,
  parameter int FUNC_BITS           = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DBITS-1:0]                     regfileOut1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]       regno1,
  input  logic [DBITS-1:0]                     regfileOut2,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]       regno2,
  input  logic [DBITS-1:0]                     imm,
  input  logic [1:0]                           aluIn2Sel,
  input  logic [FUNC_BITS-1:0]                 aluFunc,
  input  logic                                 isMul,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]       destRegno,
  input  logic                                 destWrtEn,
  input  logic [NUM_FWD*DBITS-1:0]             fwdValue,
  input  logic [NUM_FWD*REG_INDEX_BIT_WIDTH-1:0] fwdRegno,
  input  logic [NUM_FWD-1:0]                   fwdWrtEn,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DBITS-1:0]                     outResult,
  output logic [DBITS-1:0]                     outRs2,
  output logic [REG_INDEX_BIT_WIDTH-1:0]       outDestRegno,
  output logic                                 outDestWrtEn,
  output logic                                 busy
);

  localparam int RW  = REG_INDEX_BIT_WIDTH;
  localparam int SHW = $clog2(DBITS);
  localparam int CW  = $clog2(DBITS + 1);

  // Shared Alu function codes
  localparam logic [FUNC_BITS-1:0] F_ADD  = FUNC_BITS'(0);
  localparam logic [FUNC_BITS-1:0] F_SUB  = FUNC_BITS'(1);
  localparam logic [FUNC_BITS-1:0] F_AND  = FUNC_BITS'(2);
  localparam logic [FUNC_BITS-1:0] F_OR   = FUNC_BITS'(3);
  localparam logic [FUNC_BITS-1:0] F_XOR  = FUNC_BITS'(4);
  localparam logic [FUNC_BITS-1:0] F_SLL  = FUNC_BITS'(5);
  localparam logic [FUNC_BITS-1:0] F_SRL  = FUNC_BITS'(6);
  localparam logic [FUNC_BITS-1:0] F_SRA  = FUNC_BITS'(7);
  localparam logic [FUNC_BITS-1:0] F_SLT  = FUNC_BITS'(8);
  localparam logic [FUNC_BITS-1:0] F_SLTU = FUNC_BITS'(9);

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state_reg, state_next;
  logic               out_valid_reg, busy_reg, out_dest_wrt_en_reg;
  logic [DBITS-1:0]   out_result_reg, out_rs2_reg;
  logic [RW-1:0]      out_dest_regno_reg;
  logic [DBITS-1:0]   mcand_reg, mplier_reg, acc_reg, acc_next;
  logic [CW-1:0]      counter_reg;

  logic [DBITS-1:0]   fwd_val [NUM_FWD];
  logic [NUM_FWD-1:0] hit1, hit2;
  logic [DBITS-1:0]   rs1, rs2, in2, alu_result;
  logic               accept, mul_done;

  generate
    for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_fwd
      assign fwd_val[gi] = fwdValue[gi*DBITS +: DBITS];
      assign hit1[gi]    = fwdWrtEn[gi] && (fwdRegno[gi*RW +: RW] == regno1);
      assign hit2[gi]    = fwdWrtEn[gi] && (fwdRegno[gi*RW +: RW] == regno2);
    end
  endgenerate

  // Walk from oldest to youngest so the lowest matching index wins.
  always_comb begin
    rs1 = regfileOut1;
    rs2 = regfileOut2;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (hit1[i]) rs1 = fwd_val[i];
      if (hit2[i]) rs2 = fwd_val[i];
    end
    case (aluIn2Sel)
      2'd0:    in2 = rs2;
      2'd1:    in2 = imm;
      default: in2 = '0;
    endcase
  end

  always_comb begin
    case (aluFunc)
      F_ADD:   alu_result = rs1 + in2;
      F_SUB:   alu_result = rs1 - in2;
      F_AND:   alu_result = rs1 & in2;
      F_OR:    alu_result = rs1 | in2;
      F_XOR:   alu_result = rs1 ^ in2;
      F_SLL:   alu_result = rs1 << in2[SHW-1:0];
      F_SRL:   alu_result = rs1 >> in2[SHW-1:0];
      F_SRA:   alu_result = $unsigned($signed(rs1) >>> in2[SHW-1:0]);
      F_SLT:   alu_result = DBITS'($signed(rs1) < $signed(in2));
      F_SLTU:  alu_result = DBITS'(rs1 < in2);
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    in_ready   = (state_reg == IDLE) && (!out_valid_reg || out_ready) && !flush;
    accept     = in_valid && in_ready;
    mul_done   = (state_reg == MUL) && (counter_reg == CW'(1));
    acc_next   = mplier_reg[0] ? acc_reg + mcand_reg : acc_reg;
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && isMul) state_next = MUL;
      MUL:     if (mul_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg           <= IDLE;
      out_valid_reg       <= 1'b0;
      out_result_reg      <= '0;
      out_rs2_reg         <= '0;
      out_dest_regno_reg  <= '0;
      out_dest_wrt_en_reg <= 1'b0;
      busy_reg            <= 1'b0;
      counter_reg         <= '0;
      mcand_reg           <= '0;
      mplier_reg          <= '0;
      acc_reg             <= '0;
    end else begin
      state_reg <= state_next;
      if (flush) begin
        out_valid_reg <= 1'b0;
        busy_reg      <= 1'b0;
        counter_reg   <= '0;
      end else begin
        if (out_valid_reg && out_ready) out_valid_reg <= 1'b0;
        if (accept) begin
          out_rs2_reg         <= rs2;
          out_dest_regno_reg  <= destRegno;
          out_dest_wrt_en_reg <= destWrtEn;
          if (isMul) begin
            mcand_reg   <= rs1;
            mplier_reg  <= in2;
            acc_reg     <= '0;
            counter_reg <= CW'(DBITS);
            busy_reg    <= 1'b1;
          end else begin
            out_result_reg <= alu_result;
            out_valid_reg  <= 1'b1;
          end
        end
        // One shift-add step per cycle; the last step writes straight to the result.
        if (state_reg == MUL) begin
          acc_reg     <= acc_next;
          mcand_reg   <= mcand_reg << 1;
          mplier_reg  <= mplier_reg >> 1;
          counter_reg <= counter_reg - CW'(1);
          if (mul_done) begin
            out_result_reg <= acc_next;
            out_valid_reg  <= 1'b1;
            busy_reg       <= 1'b0;
          end
        end
      end
    end
  end

  assign out_valid    = out_valid_reg;
  assign outResult    = out_result_reg;
  assign outRs2       = out_rs2_reg;
  assign outDestRegno = out_dest_regno_reg;
  assign outDestWrtEn = out_dest_wrt_en_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_exec_stage_pipelined.sv
// Directed and randomized bench for exec_stage_pipelined against an operand/ALU/product model.
module tb_exec_stage_pipelined;
  localparam int DB = 32, RW = 4, NF = 2, FB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush, in_valid, in_ready, isMul, destWrtEn;
  logic [DB-1:0] regfileOut1, regfileOut2, imm;
  logic [RW-1:0] regno1, regno2, destRegno;
  logic [1:0] aluIn2Sel;
  logic [FB-1:0] aluFunc;
  logic [DB-1:0] fv [NF];
  logic [RW-1:0] fr [NF];
  logic [NF-1:0] fe;
  logic [NF*DB-1:0] fwdValue;
  logic [NF*RW-1:0] fwdRegno;
  logic out_valid, out_ready, outDestWrtEn, busy;
  logic [DB-1:0] outResult, outRs2;
  logic [RW-1:0] outDestRegno;

  assign fwdValue = {fv[1], fv[0]};
  assign fwdRegno = {fr[1], fr[0]};

  exec_stage_pipelined #(.DBITS(DB), .REG_INDEX_BIT_WIDTH(RW), .NUM_FWD(NF), .FUNC_BITS(FB)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .regfileOut1(regfileOut1), .regno1(regno1), .regfileOut2(regfileOut2), .regno2(regno2),
    .imm(imm), .aluIn2Sel(aluIn2Sel), .aluFunc(aluFunc), .isMul(isMul),
    .destRegno(destRegno), .destWrtEn(destWrtEn), .fwdValue(fwdValue), .fwdRegno(fwdRegno),
    .fwdWrtEn(fe), .out_valid(out_valid), .out_ready(out_ready), .outResult(outResult),
    .outRs2(outRs2), .outDestRegno(outDestRegno), .outDestWrtEn(outDestWrtEn), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Youngest enabled matching source wins, else regfile.
  function automatic logic [31:0] resolve(input logic [31:0] rf, input logic [3:0] rn);
    for (int i = 0; i < NF; i++)
      if (fe[i] && fr[i] == rn) return fv[i];
    return rf;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (f)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return $unsigned($signed(a) >>> sh);
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] expected_result();
    logic [31:0] a, b;
    logic [63:0] p;
    a = resolve(regfileOut1, regno1);
    b = (aluIn2Sel == 2'd0) ? resolve(regfileOut2, regno2) : (aluIn2Sel == 2'd1) ? imm : 32'd0;
    p = 64'(a) * 64'(b);
    return isMul ? p[31:0] : alu_ref(aluFunc, a, b);
  endfunction

  task automatic set_op(input logic [31:0] r1, input logic [3:0] n1, input logic [31:0] r2,
                        input logic [3:0] n2, input logic [31:0] im, input logic [1:0] sel,
                        input logic [3:0] fn, input logic mul, input logic [3:0] dr, input logic dw);
    regfileOut1 = r1; regno1 = n1; regfileOut2 = r2; regno2 = n2; imm = im;
    aluIn2Sel = sel; aluFunc = fn; isMul = mul; destRegno = dr; destWrtEn = dw;
    in_valid = 1'b1;
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] er;
    int busy_cnt, rdy_bad, lat;
    fe = '0;
    set_op(a, 4'd1, b, 4'd2, 32'd0, 2'd0, 4'd0, 1'b1, 4'd5, 1'b1);
    er = expected_result();
    #1 check({tag, "_ready_in"}, in_ready, 1);
    tick();
    in_valid = 1'b0; isMul = 1'b0;
    busy_cnt = 0; rdy_bad = 0; lat = -1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin lat = c; break; end
      if (busy) busy_cnt++;
      if (in_ready) rdy_bad++;
      tick();
    end
    check({tag, "_latency"}, lat, 32);
    check({tag, "_busy_cycles"}, busy_cnt, 32);
    check({tag, "_ready_low"}, rdy_bad, 0);
    check({tag, "_result"}, outResult, er);
    check({tag, "_dest"}, outDestRegno, 5);
    check({tag, "_busy_end"}, busy, 0);
    tick();
    check({tag, "_drained"}, out_valid, 0);
  endtask

  initial begin
    logic [31:0] er, ers2;
    logic [3:0] edr;
    logic edw;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; fe = '0;
    fv[0] = '0; fv[1] = '0; fr[0] = '0; fr[1] = '0;
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_result", outResult, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // forwarding priority
    fv[0] = 32'hAA; fv[1] = 32'hBB; fr[0] = 4'd3; fr[1] = 4'd3; fe = 2'b11;
    set_op(32'd1, 4'd3, 32'd0, 4'd0, 32'd0, 2'd1, 4'd0, 1'b0, 4'd1, 1'b1);
    tick(); check("fwd_both", outResult, 32'hAA); check("fwd_both_v", out_valid, 1);
    fe = 2'b10;
    tick(); check("fwd_src1", outResult, 32'hBB);
    fe = 2'b00;
    tick(); check("fwd_none", outResult, 32'd1);
    in_valid = 1'b0;
    tick(); check("fwd_drain", out_valid, 0);

    // random ALU ops back to back
    for (int i = 0; i < 12; i++) begin
      fe = 2'($urandom_range(0, 3));
      fr[0] = 4'($urandom_range(0, 3)); fr[1] = 4'($urandom_range(0, 3));
      fv[0] = $urandom; fv[1] = $urandom;
      set_op($urandom, 4'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 3)), $urandom,
             2'($urandom_range(0, 3)), 4'($urandom_range(0, 9)), 1'b0,
             4'($urandom), 1'($urandom));
      er = expected_result(); ers2 = resolve(regfileOut2, regno2);
      edr = destRegno; edw = destWrtEn;
      tick();
      check($sformatf("alu%0d_valid", i), out_valid, 1);
      check($sformatf("alu%0d_result", i), outResult, er);
      check($sformatf("alu%0d_rs2", i), outRs2, ers2);
      check($sformatf("alu%0d_dreg", i), outDestRegno, edr);
      check($sformatf("alu%0d_dwen", i), outDestWrtEn, edw);
    end
    in_valid = 1'b0; fe = '0;
    tick();

    // backpressure
    out_ready = 1'b0;
    set_op(32'd5, 4'd1, 32'd0, 4'd2, 32'd7, 2'd1, 4'd0, 1'b0, 4'd2, 1'b1);
    tick(); check("bp_valid", out_valid, 1); check("bp_result", outResult, 12);
    set_op(32'd1, 4'd1, 32'd0, 4'd2, 32'd2, 2'd1, 4'd0, 1'b0, 4'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready_low", in_ready, 0);
      tick();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_result", outResult, 12);
      check("bp_hold_dest", outDestRegno, 2);
    end
    out_ready = 1'b1;
    #1 check("bp_ready_high", in_ready, 1);
    tick(); check("bp_next_result", outResult, 3); check("bp_next_dest", outDestRegno, 3);
    in_valid = 1'b0;
    tick();

    // multiplies
    run_mul(32'd7, 32'd6, "mul_7x6");
    run_mul(32'hFFFF_FFFF, 32'd2, "mul_wrap");
    run_mul(32'h8000_0000, 32'h8000_0000, "mul_zero");
    run_mul($urandom, $urandom, "mul_rand");

    // flush mid-multiply
    set_op(32'd9, 4'd1, 32'd9, 4'd2, 32'd0, 2'd0, 4'd0, 1'b1, 4'd4, 1'b1);
    tick(); in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("fl_busy_before", busy, 1);
    flush = 1'b1;
    #1 check("fl_ready_during", in_ready, 0);
    tick(); flush = 1'b0;
    check("fl_busy", busy, 0); check("fl_valid", out_valid, 0);
    #1 check("fl_ready", in_ready, 1);
    set_op(32'd1, 4'd1, 32'd0, 4'd2, 32'd1, 2'd1, 4'd0, 1'b0, 4'd6, 1'b1);
    tick(); check("fl_add_valid", out_valid, 1); check("fl_add_result", outResult, 2);
    in_valid = 1'b0;
    tick();

    // reset mid-multiply
    set_op(32'd3, 4'd1, 32'd3, 4'd2, 32'd0, 2'd0, 4'd0, 1'b1, 4'd7, 1'b1);
    tick(); in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    check("rm_valid", out_valid, 0); check("rm_result", outResult, 0);
    check("rm_rs2", outRs2, 0); check("rm_dreg", outDestRegno, 0);
    check("rm_dwen", outDestWrtEn, 0); check("rm_busy", busy, 0);
    #1 check("rm_ready", in_ready, 1);

    // eight adds back to back
    for (int i = 0; i < 8; i++) begin
      set_op($urandom, 4'd1, 32'd0, 4'd2, $urandom, 2'd1, 4'd0, 1'b0, 4'(i), 1'b1);
      er = expected_result();
      tick();
      check($sformatf("b2b%0d_valid", i), out_valid, 1);
      check($sformatf("b2b%0d_result", i), outResult, er);
    end
    in_valid = 1'b0;
    tick(); check("b2b_drain", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/exec_stage_pipelined.md
Name: exec_stage_pipelined

Overview:
- Registered execute stage: resolves rs1/rs2 against NUM_FWD forwarding sources, runs single-cycle ALU ops through the shared Alu, and runs multiplies on an iterative shift-add unit.
- Sits between the decode/regfile-read stage and the memory stage.
- Valid/ready handshakes on input and output let multi-cycle multiplies stall decode.

Parameters:
DBITS, 32, datapath width
REG_INDEX_BIT_WIDTH, 4, register index width
NUM_FWD, 2, number of forwarding sources; index 0 is youngest (highest priority)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
flush  input  1  synchronous kill of in-flight and held results
in_valid  input  1  decode presents an instruction
in_ready  output  1  stage can accept this cycle
regfileOut1  input  DBITS  rs1 value from regfile
regno1  input  REG_INDEX_BIT_WIDTH  rs1 index
regfileOut2  input  DBITS  rs2 value from regfile
regno2  input  REG_INDEX_BIT_WIDTH  rs2 index
imm  input  DBITS  immediate
aluIn2Sel  input  2  ALUIN2SEL_REG / _IMM / _ZERO; encoding 3 selects zero
aluFunc  input  FUNC_BITS  shared Alu function code
isMul  input  1  multiply instead of ALU op
destRegno  input  REG_INDEX_BIT_WIDTH  destination index
destWrtEn  input  1  destination write enable
fwdValue  input  NUM_FWD*DBITS  packed forward values, source i at [i*DBITS +: DBITS]
fwdRegno  input  NUM_FWD*REG_INDEX_BIT_WIDTH  packed forward indices
fwdWrtEn  input  NUM_FWD  forward write enables
out_valid  output  1  result register holds a valid result
out_ready  input  1  downstream accepts result
outResult  output  DBITS  ALU result or low DBITS bits of product
outRs2  output  DBITS  resolved rs2, captured at accept (store data)
outDestRegno  output  REG_INDEX_BIT_WIDTH  captured destRegno
outDestWrtEn  output  1  captured destWrtEn
busy  output  1  multiplier iterating

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, out_valid=0, outResult=0, outRs2=0, outDestRegno=0, outDestWrtEn=0, busy=0, counter=0. Reset overrides flush and accept. Reset mid-multiply discards the multiply.
- Forwarding (combinational):
  - For each operand, the lowest index i with fwdWrtEn[i]=1 and fwdRegno[i]==regno wins; otherwise the regfile value is used.
  - Register 0 gets no special treatment.
  - Operands are sampled only at the accept edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush. Accept = in_valid && in_ready.
- States: IDLE, MUL.
- IDLE, accept, isMul=0:
  - Same edge: outResult <= Alu(rs1, in2); outRs2, outDestRegno and outDestWrtEn captured; out_valid <= 1.
  - Latency 1. Throughput one instruction per cycle when out_ready is held high.
- IDLE, accept, isMul=1:
  - Capture multiplicand = rs1, multiplier = in2, accumulator = 0, counter = DBITS, plus rs2/dest fields.
  - Go to MUL; busy=1; out_valid <= 0 if the previous result is consumed this edge.
- MUL:
  - Each cycle: if multiplier LSB is set, accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter decrements.
  - All arithmetic is modulo 2^DBITS (unsigned/low-half product; identical for signed low half).
  - When counter reaches 0, outResult <= accumulator, out_valid <= 1, state IDLE, busy <= 0. out_valid is first visible DBITS cycles after the accept edge.
- Output hold: while out_valid && !out_ready, all out* fields are frozen. If out_valid && out_ready && no new result, out_valid <= 0.
- flush=1 (rst_n=1): out_valid <= 0, state IDLE, busy <= 0, counter <= 0. No accept that cycle. Data registers may keep stale values.
- The input is not consumed while in_ready=0; decode must hold its inputs stable.

Test Plan:
- Forward priority: regno1=3, regfileOut1=1, fwd0={3,en,0xAA}, fwd1={3,en,0xBB}, add imm 0 -> outResult=0xAA. With fwd0 en=0 -> 0xBB. With both disabled -> 1.
- ALU backpressure: add rs1=5, imm=7, out_ready=0 for 3 cycles -> out_valid=1, outResult=12 held constant, in_ready=0. After out_ready=1 the next add is accepted the same cycle.
- Multiply: rs1=7, rs2=6, isMul, REG sel -> busy=1 for 32 cycles, in_ready=0. out_valid rises 32 cycles after accept, outResult=42.
- Wrap: 0xFFFFFFFF * 2 -> outResult=0xFFFFFFFE. 0x80000000 * 0x80000000 -> 0.
- Flush mid-multiply at cycle 10 -> busy=0, out_valid=0 next edge, in_ready=1. A following add 1+1 produces 2.
- Reset mid-multiply (rst_n=0 one cycle) -> all outputs zero, state IDLE. 8 back-to-back adds with out_ready=1 produce 8 results in 8 consecutive cycles.
